// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EXE hazard inputs and the PC/IF/ID/ID/EXE controls.
// master = pipeline side, slave = hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 32
);
  logic [REG_W-1:0] ID_rs;
  logic [REG_W-1:0] ID_rt;
  logic             ID_useRs;
  logic             ID_useRt;
  logic             ID_isBranch;
  logic             ID_branchTaken;
  logic             EXE_memRead;
  logic             EXE_regWrite;
  logic [REG_W-1:0] EXE_dst;
  logic             pcWrite;
  logic             IFID_write;
  logic             IFID_flush;
  logic             IDEXE_bubble;
  logic [CNT_W-1:0] stallCount;
  logic [CNT_W-1:0] flushCount;

  modport master (
    output ID_rs, ID_rt, ID_useRs, ID_useRt, ID_isBranch, ID_branchTaken,
           EXE_memRead, EXE_regWrite, EXE_dst,
    input  pcWrite, IFID_write, IFID_flush, IDEXE_bubble, stallCount, flushCount
  );

  modport slave (
    input  ID_rs, ID_rt, ID_useRs, ID_useRt, ID_isBranch, ID_branchTaken,
           EXE_memRead, EXE_regWrite, EXE_dst,
    output pcWrite, IFID_write, IFID_flush, IDEXE_bubble, stallCount, flushCount
  );
endinterface

// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: load-use / branch-on-ALU / branch-on-load stalls and branch flush.
// Optional saturating stall/flush event counters when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  hazard_ctrl_if.slave hz
);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  state_t state;
  logic   match_s, match_t, dep;
  logic   load_use, br_alu, br_load;
  logic   stall, flush;

  always_comb begin
    match_s  = hz.ID_useRs & (hz.ID_rs == hz.EXE_dst) & (hz.EXE_dst != REG_W'(0));
    match_t  = hz.ID_useRt & (hz.ID_rt == hz.EXE_dst) & (hz.EXE_dst != REG_W'(0));
    dep      = match_s | match_t;
    load_use = hz.EXE_memRead & dep;
    br_alu   = hz.ID_isBranch & hz.EXE_regWrite & ~hz.EXE_memRead & dep;
    br_load  = hz.ID_isBranch & hz.EXE_memRead & dep;
    // Outputs are gated by reset so they read idle while rst is low, whatever the inputs.
    stall    = rst & ((state == HOLD) | load_use | br_alu | br_load);
    flush    = rst & ~stall & hz.ID_branchTaken;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else if (state == RUN && br_load) begin
      state <= HOLD;
    end else begin
      state <= RUN;
    end
  end

  assign hz.pcWrite      = ~stall;
  assign hz.IFID_write   = ~stall;
  assign hz.IDEXE_bubble = stall;
  assign hz.IFID_flush   = flush;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign hz.stallCount = stall_cnt;
  assign hz.flushCount = flush_cnt;
`else
  logic [CNT_W-1:0] zero_cnt;
  assign zero_cnt      = '0;
  assign hz.stallCount = zero_cnt;
  assign hz.flushCount = zero_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-cycle expectations queued as stimulus is driven,
// popped and checked just after the inputs settle, well before the next rising edge.
module tb_hazard_ctrl;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 32;

  typedef struct {
    string tag;
    logic  pc;
    logic  ifw;
    logic  fl;
    logic  bub;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  logic [CNT_W-1:0] exp_sc = '0;
  logic [CNT_W-1:0] exp_fc = '0;

  hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hz ();

  hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, queue expectation, check 1ns later.
  task automatic cyc(input string tag, input logic r,
                     input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                     input logic urs, input logic urt, input logic isb, input logic bt,
                     input logic mr, input logic rw, input logic [REG_W-1:0] dst,
                     input logic es, input logic ef);
    exp_t e;
    @(negedge clk);
    rst = r;
    hz.ID_rs = rs;  hz.ID_rt = rt;  hz.ID_useRs = urs;  hz.ID_useRt = urt;
    hz.ID_isBranch = isb;  hz.ID_branchTaken = bt;
    hz.EXE_memRead = mr;  hz.EXE_regWrite = rw;  hz.EXE_dst = dst;
    if (!r) begin
      exp_sc = '0;
      exp_fc = '0;
    end
    sb.push_back('{tag: tag, pc: ~es, ifw: ~es, fl: ef, bub: es});
    #1;
    e = sb.pop_front();
    chk({e.tag, ".pcWrite"},      CNT_W'(hz.pcWrite),      CNT_W'(e.pc));
    chk({e.tag, ".IFID_write"},   CNT_W'(hz.IFID_write),   CNT_W'(e.ifw));
    chk({e.tag, ".IFID_flush"},   CNT_W'(hz.IFID_flush),   CNT_W'(e.fl));
    chk({e.tag, ".IDEXE_bubble"}, CNT_W'(hz.IDEXE_bubble), CNT_W'(e.bub));
`ifdef HAZARD_PERF_CNT_EN
    chk({e.tag, ".stallCount"}, hz.stallCount, exp_sc);
    chk({e.tag, ".flushCount"}, hz.flushCount, exp_fc);
`else
    chk({e.tag, ".stallCount"}, hz.stallCount, '0);
    chk({e.tag, ".flushCount"}, hz.flushCount, '0);
`endif
    if (r) begin
      if (es && exp_sc != '1) exp_sc = exp_sc + 1'b1;
      if (ef && exp_fc != '1) exp_fc = exp_fc + 1'b1;
    end
  endtask

  initial begin
    hz.ID_rs = '0;  hz.ID_rt = '0;  hz.ID_useRs = 1'b0;  hz.ID_useRt = 1'b0;
    hz.ID_isBranch = 1'b0;  hz.ID_branchTaken = 1'b0;
    hz.EXE_memRead = 1'b0;  hz.EXE_regWrite = 1'b0;  hz.EXE_dst = '0;

    //      tag            rst rs  rt  urs urt isb bt  mr  rw  dst  stall flush
    cyc("reset_gate",     0,  9,  9,  1,  1,  1,  1,  1,  1,  9,   0,    0);
    cyc("idle",           1,  0,  0,  0,  0,  0,  0,  0,  0,  0,   0,    0);
    cyc("load_use",       1,  8,  0,  1,  0,  0,  0,  1,  1,  8,   1,    0);
    cyc("after_load_use", 1,  8,  0,  1,  0,  0,  0,  0,  1,  8,   0,    0);
    cyc("br_load_run",    1,  0,  9,  0,  1,  1,  0,  1,  1,  9,   1,    0);
    cyc("br_load_hold",   1,  0,  0,  0,  0,  0,  0,  0,  0,  0,   1,    0);
    cyc("br_load_done",   1,  0,  0,  0,  0,  0,  0,  0,  0,  0,   0,    0);
    cyc("zero_reg",       1,  0,  0,  1,  0,  0,  0,  1,  1,  0,   0,    0);
    cyc("no_use_rs",      1,  5,  0,  0,  0,  0,  0,  1,  1,  5,   0,    0);
    cyc("br_alu_taken",   1,  3,  0,  1,  0,  1,  1,  0,  1,  3,   1,    0);
    cyc("flush",          1,  3,  0,  1,  0,  1,  1,  0,  0,  0,   0,    1);
    cyc("br_no_write",    1,  0,  4,  0,  1,  1,  0,  0,  0,  4,   0,    0);
    cyc("lu_and_brload",  1,  7,  7,  1,  1,  1,  0,  1,  1,  7,   1,    0);
    cyc("hold_ign_taken", 1,  7,  7,  1,  1,  1,  1,  1,  1,  7,   1,    0);
    cyc("b2b_load_use",   1, 10,  0,  1,  0,  0,  0,  1,  1, 10,   1,    0);
    cyc("b2b_idle",       1,  0,  0,  0,  0,  0,  0,  0,  0,  0,   0,    0);
    cyc("brload_pre_rst", 1,  2,  0,  1,  0,  1,  0,  1,  1,  2,   1,    0);
    cyc("reset_in_hold",  0,  2,  0,  1,  0,  1,  0,  1,  1,  2,   0,    0);
    cyc("post_reset",     1,  0,  0,  0,  0,  0,  0,  0,  0,  0,   0,    0);
    cyc("fresh_brload",   1,  0,  6,  0,  1,  1,  0,  1,  1,  6,   1,    0);
    cyc("fresh_hold",     1,  0,  0,  0,  0,  0,  1,  0,  0,  0,   1,    0);
    cyc("flush_after",    1,  0,  0,  0,  0,  1,  1,  0,  0,  0,   0,    1);
    cyc("final_idle",     1,  0,  0,  0,  0,  0,  0,  0,  0,  0,   0,    0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
